baud_tick_gen: RTL
==================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50000000, meaning the input clock frequency.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning oversample ticks per bit; legal values are 8 or 16.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 24, meaning the phase-accumulator width in fractional mode.
REQ-004 The block SHALL have port clock, input, 1 bit: the single system clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: run when high; hold when low.
REQ-007 The block SHALL have port baudrate_sel, input, 3 bits: requested rate index.
REQ-008 The block SHALL have port resync, input, 1 bit: single-cycle phase restart (RX start-bit alignment).
REQ-009 The block SHALL have port os_tick, output, 1 bit: single-cycle oversample strobe.
REQ-010 The block SHALL have port uart_enable, output, 1 bit: single-cycle bit-rate strobe.
REQ-011 The block SHALL have port os_phase, output, $clog2(OVERSAMPLE) bits: current oversample index.
REQ-012 The block SHALL have port rate_active, output, 3 bits: rate index currently in use.

Function
REQ-013 Rate table SHALL be: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600 baud.
REQ-014 Integer mode SHALL use DIV=round(CLK_FREQ_HZ/(baud*OVERSAMPLE)), clamped to at least 1.
REQ-015 In integer mode, a prescaler SHALL count DIV-1 down to 0, pulse os_tick on 0, and reload.
REQ-016 os_phase SHALL increment on every os_tick and wrap from OVERSAMPLE-1 to 0.
REQ-017 uart_enable SHALL pulse in the same cycle as the os_tick that wraps os_phase to 0.
REQ-018 While enable is low, the prescaler/accumulator and os_phase SHALL be held at 0, and both strobes SHALL be 0.
REQ-019 A baudrate_sel change SHALL be latched into rate_active only on a uart_enable cycle, a resync cycle, or while enable is low; no tick period is ever truncated.
REQ-020 resync SHALL clear the prescaler/accumulator and os_phase in that cycle, suppress any coincident strobe, and apply a pending rate.
REQ-021 After resync or enable rising, the first os_tick SHALL occur exactly DIV cycles later in integer mode.
REQ-022 Strobes SHALL be registered outputs, with no combinational path from inputs to outputs.

Reset
REQ-023 Assertion of reset_n low SHALL asynchronously force os_tick=0, uart_enable=0, os_phase=0, rate_active=0, and prescaler/accumulator=0.
REQ-024 Deassertion of reset_n SHALL be sampled synchronously; counting starts on the first clock edge with enable high.

Configuration
REQ-025 When BAUD_FRAC_EN is defined, the prescaler SHALL be replaced by an ACC_WIDTH-bit accumulator that adds INC=round(baud*OVERSAMPLE*2^ACC_WIDTH/CLK_FREQ_HZ) each cycle; os_tick SHALL be the carry-out.
REQ-026 When BAUD_FRAC_EN is undefined, integer division per REQ-014/015 SHALL apply, and no accumulator logic is synthesised.

Structure
REQ-027 Package baud_pkg SHALL hold the rate table, the DIV/INC constant functions, and the rate index typedef.
REQ-028 A single sub-module, baud_prescaler, SHALL implement the integer/fractional os_tick source; the top block handles phase, latching and resync.

Verification
REQ-029 Integer mode, 50 MHz, sel=4, enable=1: os_tick SHALL occur every 27 cycles and uart_enable every 432 cycles.
REQ-030 Integer mode, sel=0: DIV SHALL be 326 and uart_enable SHALL occur every 5216 cycles.
REQ-031 BAUD_FRAC_EN, sel=4, 1,000,000 cycles: the os_tick count SHALL be 36864 ±1 (INC=618475).
REQ-032 Change sel 4->2 mid-bit: rate_active SHALL remain 4 until the next uart_enable; the next bit period SHALL be 1296 cycles.
REQ-033 Pulse resync 5 cycles before a due os_tick: that tick SHALL be suppressed, os_phase=0, and the next os_tick SHALL follow 27 cycles after resync.
REQ-034 Assert reset_n low mid-count, then release: all outputs SHALL be 0 immediately, and the first os_tick SHALL occur DIV cycles after the first enabled edge.

Source files
------------

// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the baud tick generator: the supported rate table,
// the rate index type, and constant functions that turn a rate index into
// either an integer prescaler divisor (DIV) or a phase-accumulator
// increment (INC). The functions are only evaluated at elaboration time to
// build constant lookup tables, so no divider hardware is produced.
// ---------------------------------------------------------------------------
package baud_pkg;

    typedef logic [2:0] rate_idx_t;

    localparam int NUM_RATES = 8;

    localparam int unsigned BAUD_TABLE [NUM_RATES] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    // DIV = round(clk / (baud * oversample)), never below 1
    function automatic int unsigned baud_div(
        input int unsigned clk_hz,
        input int unsigned oversample,
        input rate_idx_t   idx
    );
        longint unsigned den;
        longint unsigned q;
        den = 64'(BAUD_TABLE[idx]) * 64'(oversample);
        q   = (64'(clk_hz) + den / 64'd2) / den;
        if (q < 64'd1) q = 64'd1;
        return 32'(q);
    endfunction

    // INC = round(baud * oversample * 2^acc_width / clk), kept inside the
    // accumulator range so the carry-out stays a single-cycle pulse
    function automatic int unsigned baud_inc(
        input int unsigned clk_hz,
        input int unsigned oversample,
        input int unsigned acc_width,
        input rate_idx_t   idx
    );
        longint unsigned num;
        longint unsigned q;
        longint unsigned lim;
        lim = (64'd1 << acc_width) - 64'd1;
        num = (64'(BAUD_TABLE[idx]) * 64'(oversample)) << acc_width;
        q   = (num + 64'(clk_hz) / 64'd2) / 64'(clk_hz);
        if (q > lim)   q = lim;
        if (q == 64'd0) q = 64'd1;
        return 32'(q);
    endfunction

endpackage

// File: rtl/baud_prescaler.sv
// ---------------------------------------------------------------------------
// baud_prescaler
// Oversample tick source. Produces o_tick_due, a flag derived only from
// registered state that says "the next enabled clock edge is an oversample
// tick". The top registers it into os_tick.
//
// Build option: BAUD_FRAC_EN
//   undefined : integer down-counter, reloads DIV-1 and ticks on reaching 0
//   defined   : ACC_WIDTH-bit phase accumulator, tick is the carry-out
//
// Ports
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   i_clear    : hold counter/accumulator at 0 (disabled, resync, arming)
//   i_rate     : active rate index selecting DIV / INC
//   o_tick_due : next edge produces an oversample tick
// ---------------------------------------------------------------------------
module baud_prescaler
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned ACC_WIDTH   = 24
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      i_clear,
    input  rate_idx_t i_rate,
    output logic      o_tick_due
);

`ifndef BAUD_FRAC_EN

    // The slowest rate has the largest divisor, so it sizes the counter.
    localparam int unsigned DIV_MAX = baud_div(CLK_FREQ_HZ, OVERSAMPLE, 3'd0);
    localparam int          CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    logic [CNT_W-1:0] w_reload_tbl [NUM_RATES];
    logic [CNT_W-1:0] w_reload;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_unused_acc_width;

    for (genvar g = 0; g < NUM_RATES; g++) begin : g_reload
        assign w_reload_tbl[g] =
            CNT_W'(baud_div(CLK_FREQ_HZ, OVERSAMPLE, rate_idx_t'(g)) - 1);
    end

    assign w_reload           = w_reload_tbl[i_rate];
    assign w_unused_acc_width = 32'(ACC_WIDTH);

    // From the cleared value 0 the counter loads DIV-1 on the first edge and
    // reaches 0 on edge DIV; a DIV of 1 stays at 0 and ticks every edge.
    assign o_tick_due = (r_cnt == CNT_W'(1)) || (w_reload == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            r_cnt <= w_reload;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`else

    logic [ACC_WIDTH-1:0] w_inc_tbl [NUM_RATES];
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]   w_sum;

    for (genvar g = 0; g < NUM_RATES; g++) begin : g_inc
        assign w_inc_tbl[g] =
            ACC_WIDTH'(baud_inc(CLK_FREQ_HZ, OVERSAMPLE, ACC_WIDTH, rate_idx_t'(g)));
    end

    assign w_sum      = {1'b0, r_acc} + {1'b0, w_inc_tbl[i_rate]};
    assign o_tick_due = w_sum[ACC_WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

`endif

endmodule

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// UART baud strobe generator. An oversample tick (os_tick) comes from
// baud_prescaler; this block counts oversample phase, emits the bit-rate
// strobe (uart_enable) on the phase wrap, handles resync and applies rate
// changes only at bit boundaries so no tick period is ever cut short.
//
// Build option: BAUD_FRAC_EN selects the fractional accumulator in
// baud_prescaler instead of the integer divider (default: integer).
//
// Ports
//   clock        : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   enable       : run when high; everything held at 0 when low
//   baudrate_sel : requested rate index (0=9600 ... 7=921600)
//   resync       : single-cycle phase restart
//   os_tick      : registered single-cycle oversample strobe
//   uart_enable  : registered single-cycle bit-rate strobe
//   os_phase     : current oversample index
//   rate_active  : rate index currently in use
//
// OVERSAMPLE is expected to be 8 or 16.
// ---------------------------------------------------------------------------
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned ACC_WIDTH   = 24
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [2:0]                    baudrate_sel,
    input  logic                          resync,
    output logic                          os_tick,
    output logic                          uart_enable,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic [2:0]                    rate_active
);

    localparam int              PH_W    = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

    logic            r_run;
    logic            r_os_tick;
    logic            r_uart_en;
    logic [PH_W-1:0] r_phase;
    rate_idx_t       r_rate;

    logic            w_clear;
    logic            w_tick_due;
    logic            w_wrap;

    // The first enabled edge (r_run still 0) only arms the prescaler, the same
    // way a resync edge does, so both start a full DIV-cycle tick period.
    assign w_clear = !enable || resync || !r_run;
    assign w_wrap  = w_tick_due && (r_phase == PH_LAST);

    baud_prescaler #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVERSAMPLE  (OVERSAMPLE),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_prescaler (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clear    (w_clear),
        .i_rate     (r_rate),
        .o_tick_due (w_tick_due)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run     <= 1'b0;
            r_os_tick <= 1'b0;
            r_uart_en <= 1'b0;
            r_phase   <= '0;
            r_rate    <= '0;
        end else begin
            r_run <= enable;
            if (w_clear) begin
                r_os_tick <= 1'b0;
                r_uart_en <= 1'b0;
                r_phase   <= '0;
                // The arming edge alone is not a rate-change point.
                if (!enable || resync) begin
                    r_rate <= baudrate_sel;
                end
            end else begin
                r_os_tick <= w_tick_due;
                r_uart_en <= w_wrap;
                if (w_tick_due) begin
                    r_phase <= w_wrap ? '0 : r_phase + PH_W'(1);
                end
                // New rate takes effect from the prescaler reload that
                // follows this bit boundary.
                if (w_wrap) begin
                    r_rate <= baudrate_sel;
                end
            end
        end
    end

    assign os_tick     = r_os_tick;
    assign uart_enable = r_uart_en;
    assign os_phase    = r_phase;
    assign rate_active = r_rate;

endmodule
